payout_hopper_ctrl: RTL

Cash-out controller that sits on the collect side of `slot_machine`. When the player presses collect, it captures the machine's `fund` balance. It then pays that balance out as individual coins through a req/ack handshake with the coin hopper, largest denomination first. It reports progress and handles an empty hopper without losing the unpaid balance.

---
 rtl/slot_pkg.sv | 15 +
 rtl/edge_rise.sv | 21 ++
 rtl/payout_hopper_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine cash-out path.
package slot_pkg;

    localparam int FUND_W  = 10;
    localparam int COIN_1D = 1;
    localparam int COIN_2D = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        HALT     = 2'd2,
        DONE     = 2'd3
    } state_t;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level input; a held level produces a single pulse.
module edge_rise (
    input  logic clock,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic din_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            din_d <= 1'b0;
        end else begin
            din_d <= din;
        end
    end

    assign rise = din & ~din_d;

endmodule

// File: rtl/payout_hopper_ctrl.sv
// Cash-out controller: captures the fund on a collect press and pays it out coin by coin.
// Build option PAYOUT_TWO_COIN_EN enables $2 coins; without it only $1 coins are dispensed.
module payout_hopper_ctrl #(
    parameter int FUND_W = slot_pkg::FUND_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              collect,
    input  logic [FUND_W-1:0] fund,
    input  logic              coin_ack,
    input  logic              hopper_empty,
    output logic              coin_req,
    output logic              coin_sel,
    output logic [FUND_W-1:0] paid,
    output logic              busy,
    output logic              done,
    output logic              fault,
    output slot_pkg::state_t  state_dbg
);

    import slot_pkg::*;

    // Handshake: a coin transfers on every rising edge where coin_req and coin_ack are
    // both high; while coin_req is high and unacknowledged, coin_req and coin_sel hold.

    state_t            state;
    logic [FUND_W-1:0] remaining;
    logic [FUND_W-1:0] denom;
    logic [FUND_W-1:0] rem_next;
    logic              collect_rise;
    logic              xfer;
    logic              sel_load;
    logic              sel_next;
    logic              sel_rem;

    edge_rise u_collect_edge (
        .clock   (clock),
        .reset_n (reset_n),
        .din     (collect),
        .rise    (collect_rise)
    );

    assign xfer     = coin_req & coin_ack;
    assign denom    = coin_sel ? FUND_W'(COIN_2D) : FUND_W'(COIN_1D);
    assign rem_next = remaining - denom;

`ifdef PAYOUT_TWO_COIN_EN
    assign sel_load = (fund >= FUND_W'(COIN_2D));
    assign sel_next = (rem_next >= FUND_W'(COIN_2D));
    assign sel_rem  = (remaining >= FUND_W'(COIN_2D));
`else
    assign sel_load = 1'b0;
    assign sel_next = 1'b0;
    assign sel_rem  = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            paid      <= '0;
            coin_req  <= 1'b0;
            coin_sel  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (collect_rise) begin
                        remaining <= fund;
                        paid      <= '0;
                        if (fund == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= DISPENSE;
                            coin_req <= 1'b1;
                            busy     <= 1'b1;
                            coin_sel <= sel_load;
                        end
                    end
                end
                DISPENSE: begin
                    if (xfer) begin
                        remaining <= rem_next;
                        paid      <= paid + denom;
                        if (rem_next == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            coin_req <= 1'b0;
                            coin_sel <= 1'b0;
                            busy     <= 1'b0;
                        end else if (hopper_empty) begin
                            // Coin already counted; park with the balance intact.
                            state    <= HALT;
                            coin_req <= 1'b0;
                            fault    <= 1'b1;
                            coin_sel <= sel_next;
                        end else begin
                            coin_sel <= sel_next;
                        end
                    end else if (hopper_empty) begin
                        state    <= HALT;
                        coin_req <= 1'b0;
                        fault    <= 1'b1;
                    end
                end
                HALT: begin
                    if (!hopper_empty) begin
                        state    <= DISPENSE;
                        coin_req <= 1'b1;
                        fault    <= 1'b0;
                        coin_sel <= sel_rem;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule
